// File: rtl/loopback_fifo.sv
// FIFO loopback between the usb_cdc OUT and IN streams, with echo, ASCII
// case-swap echo and free-running pattern modes plus fill/transfer status.
module loopback_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               mode_i,
    input  logic                     flush_i,
    input  logic [DATA_W-1:0]        rx_data_i,
    input  logic                     rx_valid_i,
    output logic                     rx_ready_o,
    output logic [DATA_W-1:0]        tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic [1:0]               mode_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         rx_count_o,
    output logic [CNT_W-1:0]         tx_count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [1:0] {
        ModeEcho     = 2'd0,
        ModeCaseSwap = 2'd1,
        ModePattern  = 2'd2,
        ModeRsvd     = 2'd3
    } mode_e;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic [CNT_W-1:0]  rx_count_q, rx_count_d;
    logic [CNT_W-1:0]  tx_count_q, tx_count_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    mode_e             mode_q, mode_d;

    logic              full;
    logic              pat_mode;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;

    function automatic logic [DATA_W-1:0] case_swap(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        if (d[7:0] >= 8'h41 && d[7:0] <= 8'h5A) begin
            r[7:0] = d[7:0] + 8'h20;
        end else if (d[7:0] >= 8'h61 && d[7:0] <= 8'h7A) begin
            r[7:0] = d[7:0] - 8'h20;
        end
        return r;
    endfunction

    // Ready depends on registered state and flush_i only, never on tx_ready_i,
    // so a full FIFO refuses rx even when a pop happens in the same cycle.
    assign full       = (level_q == LvlW'(DEPTH));
    assign pat_mode   = (mode_q == ModePattern);
    assign rx_ready_o = !full && !flush_i && !pat_mode;
    assign push       = pat_mode ? (!full && !flush_i) : (rx_valid_i && rx_ready_o);
    assign pop        = (level_q != '0) && tx_ready_i && !flush_i;

    assign tx_valid_o = (level_q != '0);
    assign tx_data_o  = mem_q[rd_ptr_q];
    assign mode_o     = mode_q;
    assign level_o    = level_q;
    assign rx_count_o = rx_count_q;
    assign tx_count_o = tx_count_q;

    always_comb begin
        push_data  = rx_data_i;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rx_count_d = rx_count_q;
        tx_count_d = tx_count_q;
        pat_d      = pat_q;
        mode_d     = mode_q;

        unique case (mode_q)
            ModeCaseSwap: push_data = case_swap(rx_data_i);
            ModePattern:  push_data = pat_q;
            default:      push_data = rx_data_i;
        endcase

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PtrW'(1);
                tx_count_d = tx_count_q + CNT_W'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LvlW'(1);
                2'b01:   level_d = level_q - LvlW'(1);
                default: level_d = level_q;
            endcase
        end

        if (push && !pat_mode) begin
            rx_count_d = rx_count_q + CNT_W'(1);
        end
        if (push && pat_mode) begin
            pat_d = pat_q + DATA_W'(1);
        end

        // A new mode only takes effect once the buffer is drained and idle,
        // so buffered words always leave under the mode they entered with.
        if (level_q == '0 && !push) begin
            mode_d = mode_e'(mode_i);
            if (mode_d == ModePattern && !pat_mode) begin
                pat_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rx_count_q <= '0;
            tx_count_q <= '0;
            pat_q      <= '0;
            mode_q     <= ModeEcho;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rx_count_q <= rx_count_d;
            tx_count_q <= tx_count_d;
            pat_q      <= pat_d;
            mode_q     <= mode_d;
        end
    end

    // Storage is never read while level is zero, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
